gearbox_display_top: RTL and testbench

GEARBOX_DISPLAY_TOP -- requirements
Module: gearbox_display_top

---
 rtl/gearbox_pkg.sv | 47 ++++
 rtl/gearbox_tick_gen.sv | 31 +++
 rtl/gearbox_display_top.sv | 166 ++++++++++++++++
 tb/tb_gearbox_display_top.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gearbox_pkg.sv
// -----------------------------------------------------------------------------
// gearbox_pkg
// Shared types and constants for the gearbox display block.
//   gear_t      : 4-bit gear code (0 = neutral, 1..9 forward, 15 = reverse)
//   GEAR_N/R    : neutral and reverse encodings
//   SEG_*       : active-low 7-segment glyphs, bit0 = segment a .. bit6 = g
//   gear_glyph  : maps a gear code to the glyph shown on digit 0
// -----------------------------------------------------------------------------
package gearbox_pkg;

   typedef logic [3:0] gear_t;

   localparam gear_t GEAR_N = 4'd0;
   localparam gear_t GEAR_R = 4'd15;

   // Active-low patterns: a cleared bit lights the segment.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_N     = 7'h2B;  // c, e, g
   localparam logic [6:0] SEG_R     = 7'h2F;  // e, g
   localparam logic [6:0] SEG_B     = 7'h03;  // c, d, e, f, g

   function automatic logic [6:0] digit_glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd1:    g = 7'h79;
         4'd2:    g = 7'h24;
         4'd3:    g = 7'h30;
         4'd4:    g = 7'h19;
         4'd5:    g = 7'h12;
         4'd6:    g = 7'h02;
         4'd7:    g = 7'h78;
         4'd8:    g = 7'h00;
         4'd9:    g = 7'h10;
         default: g = SEG_BLANK;
      endcase
      return g;
   endfunction

   function automatic logic [6:0] gear_glyph(input gear_t gr);
      logic [6:0] g;
      if (gr == GEAR_N)      g = SEG_N;
      else if (gr == GEAR_R) g = SEG_R;
      else                   g = digit_glyph(gr);
      return g;
   endfunction

endpackage

// File: rtl/gearbox_tick_gen.sv
// -----------------------------------------------------------------------------
// gearbox_tick_gen
// Free-running divider: counts 0..DIV-1 and wraps. tick is high for exactly
// one clk while the count sits at DIV-1, so the state update happens on the
// DIV-th rising edge after reset release. No derived clock is produced.
//   clk   : system clock
//   reset : asynchronous active-low reset (counter -> 0)
//   tick  : one-clk enable pulse
// -----------------------------------------------------------------------------
module gearbox_tick_gen #(
   parameter int DIV = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/gearbox_display_top.sv
// -----------------------------------------------------------------------------
// gearbox_display_top
// Sequential gearbox: driver shift requests are latched as pending flags and
// applied once per divider tick; the resulting gear is shown on a scanned
// multi-digit 7-segment display (digit 0 = gear glyph, digit 1 = 'b' while
// braking, other digits blank).
//
// Ports
//   clk          : system clock, all flops on rising edge
//   reset        : asynchronous active-low reset
//   shift_up     : raw driver input, active high
//   shift_down   : raw driver input, active high
//   brake        : raw driver input, active high
//   seg[6:0]     : segments a..g (bit0 = a), active low, registered
//   anode[N-1:0] : digit enables, active low one-hot, registered with seg
//   gear[3:0]    : current gear (0 = N, 1..NUM_GEARS, 15 = R)
//   dbg_pending  : {pending_up, pending_down} state for observation
//
// Build option
//   GEARBOX_REVERSE_EN : when defined, neutral + down with brake engages
//                        reverse (15). When undefined, reverse does not exist.
//
// Handshake: there is no valid/ready pair; every raw input is level-sampled
// through a two-flop synchroniser, shift inputs are rising-edge detected, and
// a detected edge sets a pending flag that lives until the next tick. An edge
// detected on the tick edge itself survives into the following tick window.
// -----------------------------------------------------------------------------
module gearbox_display_top
   import gearbox_pkg::*;
#(
   parameter int CLK_DIV    = 25_000_000,
   parameter int NUM_GEARS  = 5,
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  shift_up,
   input  logic                  shift_down,
   input  logic                  brake,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [3:0]            gear,
   output logic [1:0]            dbg_pending
);

`ifdef GEARBOX_REVERSE_EN
   localparam bit REV_EN = 1'b1;
`else
   localparam bit REV_EN = 1'b0;
`endif

   localparam gear_t         TOP_GEAR  = gear_t'(NUM_GEARS);
   localparam int            SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam int            DW        = $clog2(NUM_DIGITS);
   localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

   // ---------------------------------------------------------------- inputs
   // Bit order in the synchroniser vectors: {brake, shift_down, shift_up}.
   logic [2:0] sync1, sync2;
   logic       up_prev, dn_prev;
   logic       rise_up, rise_dn, brake_s;

   assign brake_s = sync2[2];
   assign rise_up = sync2[0] & ~up_prev;
   assign rise_dn = sync2[1] & ~dn_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= '0;
         sync2   <= '0;
         up_prev <= 1'b0;
         dn_prev <= 1'b0;
      end else begin
         sync1   <= {brake, shift_down, shift_up};
         sync2   <= sync1;
         up_prev <= sync2[0];
         dn_prev <= sync2[1];
      end
   end

   // ------------------------------------------------------------------ tick
   logic tick;

   gearbox_tick_gen #(.DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // ----------------------------------------------------------- gear state
   logic  pend_up, pend_dn;
   gear_t gear_q, gear_nx;

   // Both pendings set cancel each other; brake-only downshift applies only
   // when no shift request is pending at all.
   always_comb begin
      gear_nx = gear_q;
      if (pend_up && !pend_dn) begin
         if (gear_q == GEAR_N)       gear_nx = gear_t'(1);
         else if (gear_q == GEAR_R)  gear_nx = GEAR_N;
         else if (gear_q < TOP_GEAR) gear_nx = gear_q + gear_t'(1);
      end else if (pend_dn && !pend_up) begin
         if (gear_q == GEAR_N) begin
            if (REV_EN && brake_s) gear_nx = GEAR_R;
         end else if (gear_q != GEAR_R) begin
            gear_nx = gear_q - gear_t'(1);     // 1 -> N falls out naturally
         end
      end else if (!pend_up && !pend_dn && brake_s &&
                   gear_q >= gear_t'(2) && gear_q != GEAR_R) begin
         gear_nx = gear_q - gear_t'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gear_q  <= GEAR_N;
         pend_up <= 1'b0;
         pend_dn <= 1'b0;
      end else if (tick) begin
         gear_q  <= gear_nx;
         // Clear on the tick, but keep an edge detected on this very edge.
         pend_up <= rise_up;
         pend_dn <= rise_dn;
      end else begin
         pend_up <= pend_up | rise_up;
         pend_dn <= pend_dn | rise_dn;
      end
   end

   assign gear        = gear_q;
   assign dbg_pending = {pend_up, pend_dn};

   // --------------------------------------------------------- display scan
   logic [SW-1:0]         slot;
   logic [DW-1:0]         dig;
   logic [6:0]            seg_q;
   logic [NUM_DIGITS-1:0] anode_q;

   // seg and anode are both derived from the same dig value and registered
   // together, so the segment pattern never leaks onto a neighbouring digit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot    <= '0;
         dig     <= '0;
         anode_q <= ~NUM_DIGITS'(1);
         seg_q   <= SEG_N;
      end else begin
         if (slot == SLOT_LAST) begin
            slot <= '0;
            dig  <= (dig == DIG_LAST) ? '0 : dig + DW'(1);
         end else begin
            slot <= slot + SW'(1);
         end
         anode_q <= ~(NUM_DIGITS'(1) << dig);
         if (dig == DW'(0))      seg_q <= gear_glyph(gear_q);
         else if (dig == DW'(1)) seg_q <= brake_s ? SEG_B : SEG_BLANK;
         else                    seg_q <= SEG_BLANK;
      end
   end

   assign seg   = seg_q;
   assign anode = anode_q;

endmodule

// File: tb/tb_gearbox_display_top.sv
// -----------------------------------------------------------------------------
// tb_gearbox_display_top
// Directed + randomized bench for gearbox_display_top with CLK_DIV=8,
// SCAN_DIV=2, NUM_GEARS=5, NUM_DIGITS=4. Honours GEARBOX_REVERSE_EN.
// Each "window" spans exactly one tick period starting just after a tick edge;
// the reference model decides from the request's arrival cycle which tick it
// belongs to and what gear results.
// -----------------------------------------------------------------------------
module tb_gearbox_display_top;

   localparam int CLK_DIV    = 8;
   localparam int NUM_GEARS  = 5;
   localparam int NUM_DIGITS = 4;
   localparam int SCAN_DIV   = 2;

`ifdef GEARBOX_REVERSE_EN
   localparam bit REV = 1'b1;
`else
   localparam bit REV = 1'b0;
`endif

   localparam logic [6:0] TB_BLANK = 7'h7F;
   localparam logic [6:0] TB_B     = ~7'b1111100;

   // ------------------------------------------------- clock / reset / DUT
   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic                  shift_up = 1'b0;
   logic                  shift_down = 1'b0;
   logic                  brake = 1'b0;
   logic [6:0]            seg;
   logic [NUM_DIGITS-1:0] anode;
   logic [3:0]            gear;
   logic [1:0]            dbg_pending;

   always #5 clk = ~clk;

   gearbox_display_top #(
      .CLK_DIV    (CLK_DIV),
      .NUM_GEARS  (NUM_GEARS),
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .shift_up    (shift_up),
      .shift_down  (shift_down),
      .brake       (brake),
      .seg         (seg),
      .anode       (anode),
      .gear        (gear),
      .dbg_pending (dbg_pending)
   );

   // ------------------------------------------------------ scoreboard state
   int checks = 0;
   int errors = 0;
   int model_gear = 0;
   bit carry_up = 1'b0;
   bit carry_dn = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Glyphs written as lit segments (gfedcba), then inverted for active-low.
   function automatic logic [6:0] exp_glyph(input int g);
      logic [6:0] lit;
      case (g)
         0:       lit = 7'b1010100;  // n
         15:      lit = 7'b1010000;  // r
         1:       lit = 7'b0000110;
         2:       lit = 7'b1011011;
         3:       lit = 7'b1001111;
         4:       lit = 7'b1100110;
         5:       lit = 7'b1101101;
         6:       lit = 7'b1111101;
         7:       lit = 7'b0000111;
         8:       lit = 7'b1111111;
         9:       lit = 7'b1101111;
         default: lit = 7'b0000000;
      endcase
      return ~lit;
   endfunction

   // Gear rules in plain integer terms.
   function automatic int next_gear(input int g, input bit up, input bit dn, input bit brk);
      if (up && !dn) begin
         if (g == 0)         return 1;
         if (g == 15)        return 0;
         if (g < NUM_GEARS)  return g + 1;
         return g;
      end
      if (dn && !up) begin
         if (g == 15) return 15;
         if (g >= 1)  return g - 1;
         return (brk && REV) ? 15 : 0;
      end
      if (!up && !dn && brk && g >= 2 && g != 15) return g - 1;
      return g;
   endfunction

   // ---------------------------------------------------------------- drivers
   // One tick window. A raw pulse placed at offset o (0..5) becomes pending
   // o+3 clk into the window; it counts for this tick only if that is before
   // the tick edge (cycle CLK_DIV), otherwise it carries to the next tick.
   task automatic window(input bit up, input bit dn, input bit brk, input int o);
      bit eff_up, eff_dn, new_up, new_dn;
      int prev;
      brake  = brk;
      eff_up = carry_up | (up && (o + 3 < CLK_DIV));
      eff_dn = carry_dn | (dn && (o + 3 < CLK_DIV));
      new_up = up && (o + 3 == CLK_DIV);
      new_dn = dn && (o + 3 == CLK_DIV);
      prev   = model_gear;
      for (int j = 1; j <= CLK_DIV; j++) begin
         if (j - 1 == o) begin
            shift_up   = up;
            shift_down = dn;
         end
         if (j - 1 == o + 1) begin
            shift_up   = 1'b0;
            shift_down = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         if (j < CLK_DIV) begin
            check("gear_between_ticks", 32'(gear), 32'(prev));
            check("pending_up", 32'(dbg_pending[1]), 32'(carry_up | (up && j >= o + 3)));
            check("pending_dn", 32'(dbg_pending[0]), 32'(carry_dn | (dn && j >= o + 3)));
         end else begin
            model_gear = next_gear(prev, eff_up, eff_dn, brk);
            check("gear_at_tick", 32'(gear), 32'(model_gear));
            check("pending_up_after_tick", 32'(dbg_pending[1]), 32'(new_up));
            check("pending_dn_after_tick", 32'(dbg_pending[0]), 32'(new_dn));
         end
      end
      carry_up = new_up;
      carry_dn = new_dn;
   endtask

   // Free-running scan for three tick windows (keeps window alignment).
   // The first 4 samples are skipped so the brake level has settled.
   task automatic scan(input bit brk);
      logic [NUM_DIGITS-1:0] an_q[$];
      logic [6:0]            sg_q[$];
      logic [NUM_DIGITS-1:0] exp_an;
      logic [NUM_DIGITS-1:0] one_hot;
      logic [6:0]            exp_sg;
      int idx0, c, d;
      brake = brk;
      for (int k = 0; k < 3 * CLK_DIV; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k >= 4) begin
            an_q.push_back(anode);
            sg_q.push_back(seg);
         end
      end
      idx0 = -1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         one_hot = '1;
         one_hot[i] = 1'b0;
         if (an_q[0] === one_hot) idx0 = i;
      end
      check("scan_start_onehot", 32'(idx0 >= 0), 32'd1);
      if (idx0 < 0) idx0 = 0;
      c = 0;
      for (int k = 1; k < an_q.size(); k++)
         if (c == 0 && an_q[k] !== an_q[0]) c = k;
      check("scan_first_run_len", 32'(c >= 1 && c <= SCAN_DIV), 32'd1);
      for (int k = 0; k < an_q.size(); k++) begin
         if (c == 0 || k < c) d = idx0;
         else d = (idx0 + 1 + (k - c) / SCAN_DIV) % NUM_DIGITS;
         exp_an = '1;
         exp_an[d] = 1'b0;
         if (d == 0)             exp_sg = exp_glyph(model_gear);
         else if (d == 1 && brk) exp_sg = TB_B;
         else                    exp_sg = TB_BLANK;
         check("scan_anode", 32'(an_q[k]), 32'(exp_an));
         check("scan_seg", 32'(sg_q[k]), 32'(exp_sg));
      end
   endtask

   // -------------------------------------------------------------- sequence
   int up_seq[6]    = '{1, 2, 3, 4, 5, 5};
   int brake_seq[4] = '{3, 2, 1, 1};

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("reset_gear", 32'(gear), 32'd0);
      check("reset_pending", 32'(dbg_pending), 32'd0);
      check("reset_anode", 32'(anode), 32'(4'b1110));
      check("reset_seg", 32'(seg), 32'(exp_glyph(0)));
      reset = 1'b1;
      // First tick edge is the CLK_DIV-th rising edge after release.
      repeat (CLK_DIV) @(posedge clk);
      @(negedge clk);
      check("first_tick_gear", 32'(gear), 32'd0);

      // Six up pulses on separate ticks
      for (int i = 0; i < 6; i++) begin
         window(1'b1, 1'b0, 1'b0, 0);
         check("up_sequence", 32'(gear), 32'(up_seq[i]));
      end

      // Down to 4, then brake-only for four ticks
      window(1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         window(1'b0, 1'b0, 1'b1, 0);
         check("brake_sequence", 32'(gear), 32'(brake_seq[i]));
      end

      // Back to 3, then up and down in the same window cancel
      window(1'b1, 1'b0, 1'b0, 1);
      window(1'b1, 1'b0, 1'b0, 2);
      window(1'b1, 1'b1, 1'b0, 2);
      check("both_pending_hold", 32'(gear), 32'd3);

      // Edge landing on the tick edge is kept for the following tick
      window(1'b1, 1'b0, 1'b0, 5);
      check("late_edge_held", 32'(gear), 32'd3);
      window(1'b0, 1'b0, 1'b0, 0);
      check("late_edge_applied", 32'(gear), 32'd4);

      // Down to neutral, then down with brake
      repeat (4) window(1'b0, 1'b1, 1'b0, 0);
      check("down_to_neutral", 32'(gear), 32'd0);
      window(1'b0, 1'b1, 1'b1, 0);
      check("neutral_down_brake", 32'(gear), REV ? 32'd15 : 32'd0);
      scan(1'b1);
      window(1'b0, 1'b1, 1'b0, 0);
      window(1'b1, 1'b0, 1'b0, 0);
      window(1'b0, 1'b1, 1'b0, 0);
      window(1'b0, 1'b1, 1'b0, 0);
      check("neutral_down_no_brake", 32'(gear), 32'd0);
      scan(1'b0);

      // Randomized windows
      for (int i = 0; i < 40; i++) begin
         window(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), $urandom_range(0, 5));
         if (!REV) check("no_reverse", 32'(gear == 4'd15), 32'd0);
      end

      // Reset 3 clk after an up edge, before the tick
      brake = 1'b0;
      shift_up = 1'b1;
      @(posedge clk);
      @(negedge clk);
      shift_up = 1'b0;
      repeat (2) @(negedge clk);
      check("pending_before_reset", 32'(dbg_pending[1]), 32'd1);
      reset = 1'b0;
      #1;
      check("async_reset_gear", 32'(gear), 32'd0);
      check("async_reset_pending", 32'(dbg_pending), 32'd0);
      check("async_reset_anode", 32'(anode), 32'(4'b1110));
      check("async_reset_seg", 32'(seg), 32'(exp_glyph(0)));
      model_gear = 0;
      carry_up = 1'b0;
      carry_dn = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int j = 1; j <= CLK_DIV; j++) begin
         @(posedge clk);
         @(negedge clk);
         check("post_reset_gear", 32'(gear), 32'd0);
         check("post_reset_pending", 32'(dbg_pending), 32'd0);
      end
      // Tick alignment after release: a fresh request steps at the next tick
      window(1'b1, 1'b0, 1'b0, 0);
      check("post_reset_up", 32'(gear), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
